zaxxon_wave_player: RTL and testbench

- Multi-channel sample playback engine for the Zaxxon/Super Zaxxon sound board.
- Sits between the core's sound-latch trigger bits and the SDRAM wave port (wave_addr/wave_rd/wave_data).
- Reads a per-channel header and 8-bit unsigned PCM from the downloaded wave image.
- Mixes all active channels into one signed 16-bit stream; the core drives audio_out_l/audio_out_r from that stream.

---
 rtl/zaxxon_wave_player.sv | 229 ++++++++++++++++++++++
 tb/tb_zaxxon_wave_player.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zaxxon_wave_player.sv
// Multi-channel 8-bit PCM playback engine: reads per-channel headers and sample words
// over a single-outstanding SDRAM read port and mixes active channels once per sample tick.
module zaxxon_wave_player #(
  parameter int NUM_CH     = 4,
  parameter int CLK_DIV    = 2177,
  parameter int RD_LATENCY = 4,
  parameter int GAIN_SHIFT = 6
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              pause,
  input  logic [NUM_CH-1:0] trigger,
  input  logic [NUM_CH-1:0] stop,
  input  logic [NUM_CH-1:0] loop,
  output logic [19:0]       wave_addr,
  output logic              wave_rd,
  input  logic [15:0]       wave_data,
  output logic [15:0]       audio_out,
  output logic [NUM_CH-1:0] active
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW = $clog2(CLK_DIV + 1);
  localparam int LW = $clog2(RD_LATENCY + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HDR   = 2'd1;
  localparam logic [1:0] S_MIX   = 2'd2;
  localparam logic [1:0] S_FETCH = 2'd3;

  logic [1:0]         state;
  logic [CW-1:0]      ch;
  logic [1:0]         hdr_idx;
  logic [15:0]        hdr_start_lo;
  logic [3:0]         hdr_start_hi;
  logic [15:0]        hdr_len_lo;
  logic               rd_wait;
  logic [LW-1:0]      rd_cnt;
  logic [TW-1:0]      tick_cnt;
  logic               tick_pend;
  logic [NUM_CH-1:0]  trig_d;
  logic [NUM_CH-1:0]  pending;
  logic [NUM_CH-1:0]  fetch_mask;
  logic [NUM_CH-1:0]  byte_sel;
  logic signed [19:0] acc;
  logic [19:0]        start_l [NUM_CH];
  logic [19:0]        len_l   [NUM_CH];
  logic [19:0]        ptr     [NUM_CH];
  logic [19:0]        remain  [NUM_CH];
  logic [15:0]        word    [NUM_CH];

  function automatic logic [CW-1:0] lowest(input logic [NUM_CH-1:0] m);
    lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i]) lowest = CW'(i);
  endfunction

  function automatic logic [NUM_CH-1:0] onehot(input logic [CW-1:0] i);
    onehot = NUM_CH'(1) << i;
  endfunction

  logic               tick;
  logic               rd_done;
  logic [NUM_CH-1:0]  pend_live;
  logic [NUM_CH-1:0]  fetch_left;
  logic [CW-1:0]      trig_ch;
  logic [CW-1:0]      fetch_first;
  logic [CW-1:0]      fetch_next;
  logic [19:0]        hdr_len;
  logic               mix_on;
  logic [7:0]         mix_byte;
  logic signed [19:0] mix_term;
  logic signed [19:0] acc_sum;
  logic [15:0]        sat;

  assign tick        = !pause && (tick_cnt == TW'(CLK_DIV - 1));
  assign rd_done     = rd_wait && (rd_cnt == LW'(RD_LATENCY));
  assign pend_live   = (pending | (trigger & ~trig_d)) & ~stop;
  assign fetch_left  = fetch_mask & ~onehot(ch);
  assign trig_ch     = lowest(pend_live);
  assign fetch_first = lowest(fetch_mask);
  assign fetch_next  = lowest(fetch_left);
  assign hdr_len     = {wave_data[3:0], hdr_len_lo};

  // Centre the unsigned byte around zero; modulo-2^20 arithmetic yields the signed term.
  always_comb begin
    mix_on   = active[ch] && !stop[ch];
    mix_byte = byte_sel[ch] ? word[ch][15:8] : word[ch][7:0];
    mix_term = mix_on ? signed'(({12'b0, mix_byte} - 20'd128) << GAIN_SHIFT) : 20'sd0;
    acc_sum  = acc + mix_term;
    if (acc_sum > 20'sd32767)       sat = 16'h7FFF;
    else if (acc_sum < -20'sd32768) sat = 16'h8000;
    else                            sat = acc_sum[15:0];
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= S_IDLE;
      ch         <= '0;
      hdr_idx    <= '0;
      rd_wait    <= 1'b0;
      rd_cnt     <= '0;
      wave_rd    <= 1'b0;
      wave_addr  <= '0;
      audio_out  <= '0;
      active     <= '0;
      pending    <= '0;
      trig_d     <= trigger;
      tick_cnt   <= '0;
      tick_pend  <= 1'b0;
      fetch_mask <= '0;
      acc        <= '0;
    end else begin
      wave_rd   <= 1'b0;
      trig_d    <= trigger;
      pending   <= pend_live;
      tick_pend <= tick_pend | tick;
      if (!pause) tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (rd_wait) rd_cnt <= rd_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (pend_live != '0) begin
            ch        <= trig_ch;
            pending   <= pend_live & ~onehot(trig_ch);
            hdr_idx   <= 2'd0;
            wave_addr <= 20'(trig_ch) << 2;
            wave_rd   <= 1'b1;
            rd_wait   <= 1'b1;
            rd_cnt    <= '0;
            state     <= S_HDR;
          end else if (tick_pend) begin
            tick_pend <= tick;
            ch        <= '0;
            acc       <= '0;
            state     <= S_MIX;
          end
        end

        S_HDR: begin
          if (rd_done) begin
            if (hdr_idx != 2'd3) begin
              case (hdr_idx)
                2'd0:    hdr_start_lo <= wave_data;
                2'd1:    hdr_start_hi <= wave_data[3:0];
                default: hdr_len_lo   <= wave_data;
              endcase
              hdr_idx   <= hdr_idx + 1'b1;
              wave_addr <= wave_addr + 20'd1;
              wave_rd   <= 1'b1;
              rd_cnt    <= '0;
            end else begin
              rd_wait      <= 1'b0;
              start_l[ch]  <= {hdr_start_hi, hdr_start_lo};
              ptr[ch]      <= {hdr_start_hi, hdr_start_lo};
              len_l[ch]    <= hdr_len;
              remain[ch]   <= hdr_len;
              byte_sel[ch] <= 1'b0;
              if (hdr_len != 20'd0 && !stop[ch]) begin
                active[ch] <= 1'b1;
                fetch_mask <= onehot(ch);
                state      <= S_FETCH;
              end else begin
                active[ch] <= 1'b0;
                state      <= S_IDLE;
              end
            end
          end
        end

        S_MIX: begin
          acc <= acc_sum;
          if (mix_on) begin
            byte_sel[ch] <= ~byte_sel[ch];
            remain[ch]   <= remain[ch] - 20'd1;
            if (remain[ch] == 20'd1) begin
              if (loop[ch]) begin
                ptr[ch]      <= start_l[ch];
                remain[ch]   <= len_l[ch];
                byte_sel[ch] <= 1'b0;
                fetch_mask   <= fetch_mask | onehot(ch);
              end else begin
                active[ch] <= 1'b0;
              end
            end else if (byte_sel[ch]) begin
              // High byte just consumed: advance to the next word.
              ptr[ch]    <= ptr[ch] + 20'd1;
              fetch_mask <= fetch_mask | onehot(ch);
            end
          end
          if (ch == CW'(NUM_CH - 1)) begin
            audio_out <= sat;
            state     <= S_FETCH;
          end else begin
            ch <= ch + 1'b1;
          end
        end

        default: begin
          if (!rd_wait) begin
            if (fetch_mask == '0) begin
              state <= S_IDLE;
            end else begin
              ch        <= fetch_first;
              wave_addr <= ptr[fetch_first];
              wave_rd   <= 1'b1;
              rd_wait   <= 1'b1;
              rd_cnt    <= '0;
            end
          end else if (rd_done) begin
            word[ch]   <= wave_data;
            fetch_mask <= fetch_left;
            if (fetch_left != '0) begin
              ch        <= fetch_next;
              wave_addr <= ptr[fetch_next];
              wave_rd   <= 1'b1;
              rd_cnt    <= '0;
            end else begin
              rd_wait <= 1'b0;
              state   <= S_IDLE;
            end
          end
        end
      endcase

      for (int i = 0; i < NUM_CH; i++)
        if (stop[i]) active[i] <= 1'b0;
    end
  end
endmodule

// File: tb/tb_zaxxon_wave_player.sv
// Bench for zaxxon_wave_player: SDRAM latency model, tick-aligned sampling and a
// queue of expected audio samples per scenario.
module tb_zaxxon_wave_player;
  localparam int CLK_DIV = 200;
  localparam int RDL     = 4;
  localparam int SETTLE  = 150;

  logic        clk = 1'b0;
  logic        reset, pause;
  logic [3:0]  trigger, stop, loop;
  logic [19:0] addr6, addr7;
  logic        rd6, rd7;
  logic [15:0] data6, data7, audio6, audio7;
  logic [3:0]  active6, active7;

  logic [15:0] mem [4096];
  logic [15:0] pipe6 [RDL];
  logic [15:0] pipe7 [RDL];
  logic [19:0] rd_log [$];
  logic [15:0] exp_q [$];
  logic [15:0] exp7_q [$];
  int          tcnt = 0;
  int          tick_count = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  zaxxon_wave_player #(.NUM_CH(4), .CLK_DIV(CLK_DIV), .RD_LATENCY(RDL), .GAIN_SHIFT(6)) dut (
    .clk_sys(clk), .reset(reset), .pause(pause), .trigger(trigger), .stop(stop), .loop(loop),
    .wave_addr(addr6), .wave_rd(rd6), .wave_data(data6), .audio_out(audio6), .active(active6));

  zaxxon_wave_player #(.NUM_CH(4), .CLK_DIV(CLK_DIV), .RD_LATENCY(RDL), .GAIN_SHIFT(7)) dut7 (
    .clk_sys(clk), .reset(reset), .pause(pause), .trigger(trigger), .stop(stop), .loop(loop),
    .wave_addr(addr7), .wave_rd(rd7), .wave_data(data7), .audio_out(audio7), .active(active7));

  // SDRAM model: data valid RDL cycles after the strobe cycle, garbage otherwise.
  always @(posedge clk) begin
    pipe6[0] <= rd6 ? mem[addr6[11:0]] : 16'hDEAD;
    pipe7[0] <= rd7 ? mem[addr7[11:0]] : 16'hDEAD;
    for (int i = 1; i < RDL; i++) begin
      pipe6[i] <= pipe6[i-1];
      pipe7[i] <= pipe7[i-1];
    end
    if (rd6) rd_log.push_back(addr6);
  end
  assign data6 = pipe6[RDL-1];
  assign data7 = pipe7[RDL-1];

  // Sample-rate reference: counts 0..CLK_DIV-1 while not paused.
  always @(posedge clk) begin
    if (reset) tcnt <= 0;
    else if (!pause) begin
      if (tcnt == CLK_DIV - 1) begin
        tcnt <= 0;
        tick_count <= tick_count + 1;
      end else tcnt <= tcnt + 1;
    end
  end

  task automatic wait_tick();
    int n0 = tick_count;
    int guard = 0;
    while (tick_count == n0 && guard < 4 * CLK_DIV) begin
      @(negedge clk);
      guard++;
    end
    if (tick_count == n0) begin
      n_checks++;
      $display("FAIL tick_timeout got no tick in %0d cycles, required one", guard);
    end
  endtask

  task automatic next_sample(output logic [15:0] v6, output logic [15:0] v7);
    wait_tick();
    repeat (SETTLE) @(negedge clk);
    v6 = audio6;
    v7 = audio7;
  endtask

  task automatic set_header(input int c, input logic [19:0] start, input logic [19:0] len);
    mem[4*c]   = start[15:0];
    mem[4*c+1] = {12'b0, start[19:16]};
    mem[4*c+2] = len[15:0];
    mem[4*c+3] = {12'b0, len[19:16]};
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; pause = 1'b0; trigger = '0; stop = '0; loop = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp7_q.delete();
  endtask

  task automatic pulse_trigger(input logic [3:0] m);
    wait_tick();
    repeat (20) @(negedge clk);
    rd_log.delete();
    trigger = m;
    @(negedge clk);
    trigger = '0;
  endtask

  task automatic drain(input string name);
    logic [15:0] v6, v7, e;
    while (exp_q.size() > 0) begin
      next_sample(v6, v7);
      e = exp_q.pop_front();
      $display("%s sample audio_out=%0d expected=%0d", name, $signed(v6), $signed(e));
      n_checks++;
      if (v6 !== e) $display("FAIL %s_sample got %0d required %0d", name, $signed(v6), $signed(e));
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    logic [15:0] v6, v7;
    @(negedge clk);
    reset = 1'b1; pause = 1'b0; trigger = '0; stop = '0; loop = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({audio6, active6, rd6, addr6} !== 41'd0)
      $display("FAIL reset_state got audio=%h active=%b rd=%b addr=%h required all zero", audio6, active6, rd6, addr6);
    else n_pass++;
    n_checks++;
    if ({audio7, active7, rd7, addr7} !== 41'd0)
      $display("FAIL reset_state7 got audio=%h active=%b rd=%b addr=%h required all zero", audio7, active7, rd7, addr7);
    else n_pass++;
    reset = 1'b0;
    next_sample(v6, v7);
    $display("reset idle sample audio_out=%0d", $signed(v6));
    n_checks++;
    if (v6 !== 16'h0) $display("FAIL idle_sample got %h required 0000", v6);
    else n_pass++;
  endtask

  task automatic test_one_shot();
    logic [19:0] exp_rd [5] = '{20'h0, 20'h1, 20'h2, 20'h3, 20'h100};
    bit ok;
    apply_reset();
    set_header(0, 20'h00100, 20'd4);
    mem[12'h100] = 16'h8180;
    mem[12'h101] = 16'h7F90;
    pulse_trigger(4'b0001);
    repeat (60) @(negedge clk);
    ok = (rd_log.size() == 5);
    if (ok) for (int i = 0; i < 5; i++) if (rd_log[i] !== exp_rd[i]) ok = 0;
    $display("one_shot header+preload reads=%0d", rd_log.size());
    n_checks++;
    if (!ok) $display("FAIL one_shot_reads got %0d reads (first %h) required 0,1,2,3,100", rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : 20'hFFFFF);
    else n_pass++;
    n_checks++;
    if (active6 !== 4'b0001) $display("FAIL one_shot_active got %b required 0001", active6);
    else n_pass++;
    exp_q.push_back(16'h0); exp_q.push_back(16'd64); exp_q.push_back(16'd1024); exp_q.push_back(16'(-64));
    drain("one_shot");
    n_checks++;
    if (active6 !== 4'b0000) $display("FAIL one_shot_end_active got %b required 0000", active6);
    else n_pass++;
    exp_q.push_back(16'h0);
    drain("one_shot_tail");
  endtask

  task automatic test_loop();
    apply_reset();
    set_header(0, 20'h00100, 20'd4);
    loop = 4'b0001;
    pulse_trigger(4'b0001);
    exp_q.push_back(16'h0); exp_q.push_back(16'd64); exp_q.push_back(16'd1024); exp_q.push_back(16'(-64));
    drain("loop_pass1");
    n_checks++;
    if (addr6 !== 20'h100) $display("FAIL loop_restart_addr got %h required 00100", addr6);
    else n_pass++;
    exp_q.push_back(16'h0); exp_q.push_back(16'd64); exp_q.push_back(16'd1024); exp_q.push_back(16'(-64));
    drain("loop_pass2");
    stop = 4'b0001;
    @(negedge clk);
    stop = '0;
    loop = '0;
    n_checks++;
    if (active6 !== 4'b0000) $display("FAIL loop_stop_active got %b required 0000", active6);
    else n_pass++;
  endtask

  task automatic test_saturate();
    logic [15:0] v6, v7;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      set_header(c, 20'h200 + 20'(c * 16), 20'h100);
      for (int j = 0; j < 16; j++) mem[12'h200 + c*16 + j] = 16'hFFFF;
    end
    pulse_trigger(4'b1111);
    exp_q.push_back(16'd32512);
    exp7_q.push_back(16'h7FFF);
    next_sample(v6, v7);
    $display("saturate max gain6=%0d gain7=%0d", $signed(v6), $signed(v7));
    n_checks++;
    if (v6 !== exp_q[0]) $display("FAIL sum_gain6 got %0d required %0d", $signed(v6), $signed(exp_q[0]));
    else n_pass++;
    n_checks++;
    if (v7 !== exp7_q[0]) $display("FAIL sat_pos_gain7 got %0d required %0d", $signed(v7), $signed(exp7_q[0]));
    else n_pass++;
    void'(exp_q.pop_front());
    void'(exp7_q.pop_front());
    stop = 4'b1111;
    @(negedge clk);
    stop = '0;
    for (int j = 0; j < 64; j++) mem[12'h200 + j] = 16'h0000;
    pulse_trigger(4'b1111);
    exp_q.push_back(16'h8000);
    exp7_q.push_back(16'h8000);
    next_sample(v6, v7);
    $display("saturate min gain6=%0d gain7=%0d", $signed(v6), $signed(v7));
    n_checks++;
    if (v6 !== exp_q[0]) $display("FAIL min_gain6 got %0d required %0d", $signed(v6), $signed(exp_q[0]));
    else n_pass++;
    n_checks++;
    if (v7 !== exp7_q[0]) $display("FAIL sat_neg_gain7 got %0d required %0d", $signed(v7), $signed(exp7_q[0]));
    else n_pass++;
    exp_q.delete();
    exp7_q.delete();
  endtask

  task automatic test_zero_len();
    bit ok;
    apply_reset();
    set_header(2, 20'h500, 20'd0);
    pulse_trigger(4'b0100);
    repeat (60) @(negedge clk);
    wait_tick();
    repeat (SETTLE) @(negedge clk);
    ok = (rd_log.size() == 4);
    if (ok) for (int i = 0; i < 4; i++) if (rd_log[i] !== 20'(8 + i)) ok = 0;
    $display("zero_len reads=%0d active=%b", rd_log.size(), active6);
    n_checks++;
    if (!ok) $display("FAIL zero_len_reads got %0d reads required exactly 8,9,a,b", rd_log.size());
    else n_pass++;
    n_checks++;
    if (active6 !== 4'b0000) $display("FAIL zero_len_active got %b required 0000", active6);
    else n_pass++;
  endtask

  task automatic load_ramp();
    set_header(1, 20'h300, 20'd16);
    for (int j = 0; j < 8; j++) mem[12'h300 + j] = 16'(((129 + 2*j) << 8) | (128 + 2*j));
  endtask

  task automatic test_pause();
    int changes = 0;
    apply_reset();
    load_ramp();
    pulse_trigger(4'b0010);
    for (int k = 0; k < 3; k++) exp_q.push_back(16'(k * 64));
    drain("pause_pre");
    rd_log.delete();
    pause = 1'b1;
    for (int i = 0; i < 3 * CLK_DIV; i++) begin
      @(negedge clk);
      if (audio6 !== 16'd128) changes++;
    end
    $display("pause held reads=%0d audio_changes=%0d", rd_log.size(), changes);
    n_checks++;
    if (rd_log.size() != 0) $display("FAIL pause_reads got %0d required 0", rd_log.size());
    else n_pass++;
    n_checks++;
    if (changes != 0) $display("FAIL pause_hold got %0d cycles off 128 required 0", changes);
    else n_pass++;
    pause = 1'b0;
    for (int k = 3; k < 6; k++) exp_q.push_back(16'(k * 64));
    drain("pause_post");
  endtask

  task automatic test_reset_mid_read();
    int guard = 0;
    apply_reset();
    load_ramp();
    set_header(0, 20'h00100, 20'd4);
    set_header(3, 20'h400, 20'd8);
    for (int j = 0; j < 4; j++) mem[12'h400 + j] = 16'h9090;
    pulse_trigger(4'b0010);
    exp_q.push_back(16'h0); exp_q.push_back(16'd64);
    drain("rst_pre");
    pulse_trigger(4'b0001);
    while (!rd6 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (!rd6) $display("FAIL rst_read_start got no wave_rd in %0d cycles required one", guard);
    else n_pass++;
    reset = 1'b1;
    trigger = 4'b1000;
    @(negedge clk);
    reset = 1'b0;
    rd_log.delete();
    $display("reset mid-read active=%b audio_out=%0d", active6, $signed(audio6));
    n_checks++;
    if (active6 !== 4'b0 || audio6 !== 16'h0 || rd6 !== 1'b0)
      $display("FAIL rst_mid_state got active=%b audio=%h rd=%b required 0/0000/0", active6, audio6, rd6);
    else n_pass++;
    exp_q.push_back(16'h0); exp_q.push_back(16'h0); exp_q.push_back(16'h0);
    drain("rst_post");
    n_checks++;
    if (rd_log.size() != 0 || active6 !== 4'b0)
      $display("FAIL rst_held_trigger got reads=%0d active=%b required 0/0000", rd_log.size(), active6);
    else n_pass++;
    trigger = 4'b0000;
    @(negedge clk);
    pulse_trigger(4'b1000);
    repeat (60) @(negedge clk);
    n_checks++;
    if (active6 !== 4'b1000) $display("FAIL rst_fresh_edge got active=%b required 1000", active6);
    else n_pass++;
    exp_q.push_back(16'd1024);
    drain("rst_fresh");
  endtask

  initial begin
    reset = 1'b1; pause = 1'b0; trigger = '0; stop = '0; loop = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    test_reset();
    test_one_shot();
    test_loop();
    test_saturate();
    test_zero_len();
    test_pause();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got no completion required finish before 5 ms");
    $fatal(1);
  end
endmodule
